mmio_tx_port: RTL
=================

# mmio_tx_port

Memory-mapped transmit peripheral on the CPU data bus. Responds to CPU loads and stores in a 4-word address window. Stores to the data register enter a small output FIFO. The FIFO drains to an external consumer over a valid/ready handshake. It sits beside the 256x16 RAM on the shared MemRW_IO / MemAddr_IO / MemD_IO bus and decodes only its own window.

## Interface
- BASE_ADDR, 8'hF0, base of the 4-word window; must be 4-aligned
- DEPTH, 4, FIFO depth in 16-bit words; power of two, 2..16
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- MemRW_IO  input  1  bus direction: 1 = CPU store (write), 0 = CPU load (read)
- MemAddr_IO  input  8  bus address
- MemD_IO  inout  16  shared data bus; driven by this block only during a load from its window, otherwise high-Z
- tx_data  output  16  FIFO head word
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  consumer accepts tx_data this cycle

## Operation
- sel = (MemAddr_IO[7:2] == BASE_ADDR[7:2]); offset = MemAddr_IO[1:0].
- Register map:
  - off 0 DATA: write pushes the word; read returns the FIFO head, or 16'h0000 if empty; a read never pops.
  - off 1 STATUS: read returns {drop_cnt[7:0], 3'b000, full, empty, count[2:0]}; any write clears drop_cnt.
  - off 2, 3: reserved; read 16'h0000; writes ignored.
- Write strobe:
  - A CPU store holds address and MemRW_IO for more than one cycle.
  - wr_edge = sel & MemRW_IO & ~wr_d, where wr_d is the registered value of (sel & MemRW_IO).
  - Exactly one push or clear per store.
- Read drive: MemD_IO = (sel & ~MemRW_IO) ? rdata : 16'hzzzz. rdata is combinational from registered state.
- Push:
  - On wr_edge at off 0: if not full, write at wr_ptr, wr_ptr++ (mod DEPTH), count++.
  - If full: word discarded, drop_cnt++, saturating at 255.
- Drain: tx_valid = ~empty; tx_data = mem[rd_ptr]. When tx_valid & tx_ready, rd_ptr++ (mod DEPTH), count--.
- Simultaneous push and pop:
  - When full, the push is accepted; the pop frees the slot in the same edge.
  - count is unchanged and there is no drop.
- Push while empty: tx_valid is 0 that cycle, so no pop occurs.
- Pointers: log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits. full = (count == DEPTH); empty = (count == 0).
- STATUS count field: zero-extended or truncated to 3 bits (exact for DEPTH ≤ 4).

## Timing
- Reset values: wr_ptr = rd_ptr = count = 0, drop_cnt = 0, wr_d = 0.
- Reset outputs: tx_valid = 0, tx_data = mem[0] (don't-care), MemD_IO high-Z unless a load from the window is in progress.
- Reset is synchronous and wins over any concurrent push or pop.
- Reset mid-store: wr_d is cleared. A store still held after reset releases produces one new wr_edge.
- Push latency: word written at edge N; tx_valid = 1 and tx_data valid after edge N.
- Pop: the consumer samples tx_data in the cycle where tx_valid & tx_ready; the next head is presented after that edge.
- STATUS and DATA reads reflect state after the most recent edge. There is no read latency beyond bus decode.
- Memory array is not reset.

## Structure
- Shared package mmio_pkg:
  - offset constants OFF_DATA = 2'd0, OFF_STATUS = 2'd1
  - STATUS bit positions: count [2:0], empty 3, full 4, drop_cnt [15:8]
  - default BASE_ADDR
- Sub-module sync_fifo16: DEPTH-parameterised single-clock FIFO with push, pop, full, empty, count, head.
- Top level holds: address decode, write-edge detect, drop counter, tri-state driver.

## Test plan
- Reset, then load from 0xF1: MemD_IO = 16'h0008 (empty = 1); tx_valid = 0. Load from 0x40: MemD_IO high-Z from this block.
- Store 16'h1234 to 0xF0, address and MemRW_IO held for 2 cycles, tx_ready = 0:
  - count = 1, exactly one entry
  - tx_valid = 1 and tx_data = 16'h1234 the cycle after the first store cycle
- Five stores 16'h0001..16'h0005 with tx_ready = 0:
  - STATUS = 16'h0114 (drop_cnt 1, full, count 4)
  - drain with tx_ready = 1 yields 1, 2, 3, 4 in order, then tx_valid = 0
- FIFO full, store 16'hAAAA in the same cycle as tx_ready = 1: no drop (drop_cnt unchanged), count stays 4, 16'hAAAA emerges last.
- After drops, store any value to 0xF1: drop_cnt reads 0. Store to 0xF2: no state change; load 0xF3 returns 16'h0000.
- Assert rst with 3 entries queued and a store in progress: next cycle count = 0, tx_valid = 0, drop_cnt = 0; a held store after release pushes once.

Source files
------------

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_pkg
//  Purpose  : Shared constants and helpers for the MMIO transmit port:
//             register offsets, STATUS bit positions, default window base
//             and a STATUS word packer.
//  Revision : 1.0  initial release
// ============================================================================
package mmio_pkg;

   localparam logic [7:0] BASE_ADDR_DEFAULT = 8'hF0;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_COUNT_MSB = 2;
   localparam int ST_EMPTY     = 3;
   localparam int ST_FULL      = 4;
   localparam int ST_DROP_LSB  = 8;
   localparam int ST_DROP_MSB  = 15;

   // Bits 7:5 are always zero.
   function automatic logic [15:0] pack_status(input logic [7:0] drop,
                                               input logic       full,
                                               input logic       empty,
                                               input logic [2:0] cnt);
      logic [15:0] s;
      s = '0;
      s[ST_DROP_MSB:ST_DROP_LSB]   = drop;
      s[ST_FULL]                   = full;
      s[ST_EMPTY]                  = empty;
      s[ST_COUNT_MSB:ST_COUNT_LSB] = cnt;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo16.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo16
//  Purpose  : Single-clock FIFO of 16-bit words, DEPTH entries (power of 2).
//             A push while full is accepted only when a pop happens on the
//             same edge. A pop while empty is ignored.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, push_data - write request and word
//             pop             - read request (head advances on the edge)
//             full, empty     - occupancy flags
//             count           - number of stored words
//             head            - word at the read pointer
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo16 #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [15:0]      push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [15:0]      head
);

   logic [15:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   // When full, a same-edge pop frees the slot the push lands in.
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/mmio_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_tx_port
//  Purpose  : Memory-mapped transmit port in a 4-word window on the shared
//             CPU bus. Stores to DATA enter a FIFO that drains to an
//             external consumer over valid/ready. STATUS reports occupancy
//             and a saturating drop counter (cleared by any STATUS store).
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             MemRW_IO              - 1 = store, 0 = load
//             MemAddr_IO[7:0]       - bus address
//             MemD_IO[15:0] (inout) - driven only on loads from the window
//             tx_data, tx_valid     - FIFO head and non-empty flag
//             tx_ready              - consumer accepts tx_data this cycle
//  Revision : 1.0  initial release
// ============================================================================
module mmio_tx_port
   import mmio_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEFAULT,
   parameter int         DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRW_IO,
   input  logic [7:0]  MemAddr_IO,
   inout  wire  [15:0] MemD_IO,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             sel;
   logic [1:0]       offset;
   logic             wr_req, wr_edge;
   logic             wr_d_q, wr_d_d;
   logic             push, clr;
   logic             full, empty;
   logic [CNT_W-1:0] count;
   logic [2:0]       count3;
   logic [15:0]      head;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic [15:0]      rdata;

   assign sel    = (MemAddr_IO[7:2] == BASE_ADDR[7:2]);
   assign offset = MemAddr_IO[1:0];

   // A store holds the bus for several cycles; act only on its first cycle.
   assign wr_req  = sel & MemRW_IO;
   assign wr_edge = wr_req & ~wr_d_q;
   assign wr_d_d  = wr_req;

   assign push = wr_edge & (offset == OFF_DATA);
   assign clr  = wr_edge & (offset == OFF_STATUS);

   sync_fifo16 #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (MemD_IO),
      .pop       (tx_ready),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );

   // A push into a full FIFO is only lost when no pop frees a slot.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clr)
         drop_cnt_d = '0;
      else if (push & full & ~tx_ready & (drop_cnt_q != 8'hFF))
         drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_d_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_d_q     <= wr_d_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   generate
      if (CNT_W >= 3) begin : g_cnt_trunc
         assign count3 = count[2:0];
      end else begin : g_cnt_ext
         assign count3 = {{(3-CNT_W){1'b0}}, count};
      end
   endgenerate

   always_comb begin
      rdata = 16'h0000;
      case (offset)
         OFF_DATA:   rdata = empty ? 16'h0000 : head;
         OFF_STATUS: rdata = pack_status(drop_cnt_q, full, empty, count3);
         default:    rdata = 16'h0000;
      endcase
   end

   assign MemD_IO  = (sel & ~MemRW_IO) ? rdata : 16'hzzzz;
   assign tx_valid = ~empty;
   assign tx_data  = head;

endmodule
`default_nettype wire
